pipe_stage_elastic: RTL and testbench
=====================================

// Module: pipe_stage_elastic
// PURPOSE
//  Parametrised elastic pipeline stage for inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Replaces fixed-field stall registers with a generic CTRL/DATA payload and a valid/ready handshake.
//  Uses a 2-entry skid buffer, so in_ready is registered and backpressure does not form a comb path.
//  Adds synchronous flush (branch squash) and automatic bubble insertion (ctrl zeroed when empty).
// PARAMETERS
//  DATA_W      32  width of datapath payload (pc, operands, imm, reg ids, funct fields packed)
//  CTRL_W      8   width of control payload (reg_write, mem_read, ... packed); zeroed on bubble
//  CLEAR_DATA  0   1: data regs also cleared on flush/drain; 0: data regs hold last value
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       asynchronous, active-high reset
//  flush      in   1       sync squash of all held entries (highest priority after reset)
//  in_valid   in   1       upstream payload valid
//  in_ready   out  1       stage can accept; = !skid_valid (register-driven)
//  in_ctrl    in   CTRL_W  upstream control payload
//  in_data    in   DATA_W  upstream data payload
//  out_valid  out  1       main entry valid
//  out_ready  in   1       downstream accepts (deasserted = stall)
//  out_ctrl   out  CTRL_W  main entry ctrl; all-zero whenever out_valid=0
//  out_data   out  DATA_W  main entry data
//  occupancy  out  2       entries held: 0, 1 or 2
// BEHAVIOUR
//  - Storage: main {valid,ctrl,data} drives outputs; skid {valid,ctrl,data} holds overflow.
//  - Reset (async): main/skid valid=0, ctrl=0, data=0; out_valid=0, out_ctrl=0, out_data=0,
//    occupancy=0, in_ready=1. Reset mid-transfer discards everything; no partial state survives.
//  - acc = in_valid & in_ready; ret = out_valid & out_ready. Latency: accept->out_valid = 1 cycle.
//  - State by occupancy, transitions per clock when flush=0:
//    EMPTY: acc -> ONE (main<=in).
//    ONE:   acc&ret -> ONE (main<=in); acc&!ret -> FULL (skid<=in); !acc&ret -> EMPTY.
//    FULL:  in_ready=0, so acc=0; ret -> ONE (main<=skid, skid.valid<=0); !ret -> FULL (hold).
//  - Throughput: 1 transfer/cycle sustained when out_ready=1. No in->out combinational path.
//  - Stall (out_ready=0): main held unchanged. One more beat is absorbed into skid, then in_ready=0.
//  - Flush=1: next cycle main.valid=skid.valid=0 and both ctrl=0. A payload offered on the
//    flush cycle is dropped even if in_valid=1 (acc is ignored). in_ready=1 the following cycle.
//    CLEAR_DATA=1 also zeroes data regs.
//  - Bubble: whenever an entry is invalid, its ctrl reg is 0. So out_ctrl=0 when out_valid=0,
//    and downstream sees a NOP with no side effects even if it ignores out_valid.
//  - CLEAR_DATA=1: data regs also go to 0 when the stage drains to EMPTY.
//  - ctrl/data are never modified while held; only load from in_* or skid, or clear.
//  - occupancy = main.valid + skid.valid. Invariant: skid.valid implies main.valid.
//  - out_ready is allowed while out_valid=0; it has no effect.
// TESTING
//  1 Reset: assert reset mid-burst -> same cycle out_valid=0, out_ctrl=0, occupancy=0;
//    after release in_ready=1.
//  2 Streaming: out_ready=1, in_valid=1, data 0x10,0x11,0x12,0x13 on consecutive cycles ->
//    out_data 0x10..0x13 one cycle later, no gaps, occupancy=1 throughout.
//  3 Backpressure: stream 0xA0,0xA1,0xA2 with out_ready=0 from cycle 1 -> main=0xA0,
//    skid=0xA1, in_ready=0, 0xA2 held upstream. Raise out_ready -> 0xA0,0xA1,0xA2 emerge in
//    order; none lost or duplicated.
//  4 Flush at FULL: occupancy=2, flush=1 with in_valid=1, in_data=0xFF, ctrl=0x3F ->
//    next cycle out_valid=0, out_ctrl=0x00, occupancy=0; 0xFF never appears at output.
//  5 Bubble: in_valid=0 for 2 cycles in a stream of ctrl=0x81 -> out_valid=0 and out_ctrl=0x00
//    for exactly those 2 cycles.
//  6 CLEAR_DATA=1: drain to EMPTY -> out_data=0. CLEAR_DATA=0: drain -> out_data holds the last
//    value. Run random valid/ready with a scoreboard (10k cycles) -> in-order, lossless.

Source files
------------

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage with a 2-entry skid buffer, registered in_ready, synchronous flush
// and automatic bubble insertion (ctrl forced to zero whenever an entry is invalid).
module pipe_stage_elastic #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned CTRL_W     = 8,
    parameter int unsigned CLEAR_DATA = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    localparam bit ClearData = (CLEAR_DATA != 0);

    state_e              state_q;
    logic                main_valid_q;
    logic [CTRL_W-1:0]   main_ctrl_q;
    logic [DATA_W-1:0]   main_data_q;
    logic                skid_valid_q;
    logic [CTRL_W-1:0]   skid_ctrl_q;
    logic [DATA_W-1:0]   skid_data_q;

    logic                acc;
    logic                ret;

    // A beat offered during flush is dropped, so flush masks the accept.
    assign acc = in_valid & in_ready & ~flush;
    assign ret = main_valid_q & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StEmpty;
            main_valid_q <= 1'b0;
            main_ctrl_q  <= '0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= '0;
            skid_data_q  <= '0;
        end else if (flush) begin
            state_q      <= StEmpty;
            main_valid_q <= 1'b0;
            main_ctrl_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= '0;
            if (ClearData) begin
                main_data_q <= '0;
                skid_data_q <= '0;
            end
        end else begin
            case (state_q)
                StEmpty: begin
                    if (acc) begin
                        state_q      <= StOne;
                        main_valid_q <= 1'b1;
                        main_ctrl_q  <= in_ctrl;
                        main_data_q  <= in_data;
                    end
                end
                StOne: begin
                    if (acc && ret) begin
                        main_ctrl_q <= in_ctrl;
                        main_data_q <= in_data;
                    end else if (acc) begin
                        // Downstream stalled: park the new beat, which drops in_ready next cycle.
                        state_q      <= StFull;
                        skid_valid_q <= 1'b1;
                        skid_ctrl_q  <= in_ctrl;
                        skid_data_q  <= in_data;
                    end else if (ret) begin
                        state_q      <= StEmpty;
                        main_valid_q <= 1'b0;
                        main_ctrl_q  <= '0;
                        if (ClearData) begin
                            main_data_q <= '0;
                        end
                    end
                end
                StFull: begin
                    if (ret) begin
                        state_q      <= StOne;
                        main_ctrl_q  <= skid_ctrl_q;
                        main_data_q  <= skid_data_q;
                        skid_valid_q <= 1'b0;
                        skid_ctrl_q  <= '0;
                        if (ClearData) begin
                            skid_data_q <= '0;
                        end
                    end
                end
                default: begin
                    state_q      <= StEmpty;
                    main_valid_q <= 1'b0;
                    main_ctrl_q  <= '0;
                    skid_valid_q <= 1'b0;
                    skid_ctrl_q  <= '0;
                end
            endcase
        end
    end

    assign in_ready  = ~skid_valid_q;
    assign out_valid = main_valid_q;
    assign out_ctrl  = main_ctrl_q;
    assign out_data  = main_data_q;
    assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

    skid_implies_main: assert property (@(posedge clk) disable iff (reset)
        skid_valid_q |-> main_valid_q);

    bubble_ctrl_zero: assert property (@(posedge clk) disable iff (reset)
        !main_valid_q |-> (main_ctrl_q == '0));

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Scoreboard bench for pipe_stage_elastic: one instance per CLEAR_DATA setting, shared stimulus,
// expected beats queued at issue and popped by a negedge monitor on each output transfer.
module tb_pipe_stage_elastic;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [7:0]  in_ctrl;
    logic [31:0] in_data;
    logic        out_ready;

    logic        in_ready0, out_valid0, in_ready1, out_valid1;
    logic [7:0]  out_ctrl0, out_ctrl1;
    logic [31:0] out_data0, out_data1;
    logic [1:0]  occ0, occ1;

    logic [39:0] exp_q0[$];
    logic [39:0] exp_q1[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          rnd_done;

    pipe_stage_elastic #(.DATA_W(32), .CTRL_W(8), .CLEAR_DATA(0)) dut0 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_ctrl(out_ctrl0),
        .out_data(out_data0), .occupancy(occ0)
    );

    pipe_stage_elastic #(.DATA_W(32), .CTRL_W(8), .CLEAR_DATA(1)) dut1 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_ctrl(out_ctrl1),
        .out_data(out_data1), .occupancy(occ1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string name);
        check({name, "_valid0"}, 40'(out_valid0), 40'h0);
        check({name, "_ctrl0"},  40'(out_ctrl0),  40'h0);
        check({name, "_occ0"},   40'(occ0),       40'h0);
        check({name, "_valid1"}, 40'(out_valid1), 40'h0);
        check({name, "_ctrl1"},  40'(out_ctrl1),  40'h0);
        check({name, "_occ1"},   40'(occ1),       40'h0);
    endtask

    task automatic clear_sb();
        exp_q0.delete();
        exp_q1.delete();
    endtask

    // Issue a beat, queue its expectation, hold it until accepted.
    task automatic send(input logic [7:0] c, input logic [31:0] d);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_ctrl  = c;
        in_data  = d;
        exp_q0.push_back({c, d});
        exp_q1.push_back({c, d});
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_accept: got in_ready=0 expected 1 within 100 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic mon_one(input int idx, input logic v, input logic [7:0] c,
                           input logic [31:0] d);
        logic [39:0] e;
        if (v && out_ready) begin
            if ((idx == 0 && exp_q0.size() == 0) || (idx == 1 && exp_q1.size() == 0)) begin
                n_checks++;
                n_fail++;
                $display("FAIL out%0d_unexpected: got %0h expected no beat", idx, {c, d});
            end else begin
                if (idx == 0) e = exp_q0.pop_front();
                else          e = exp_q1.pop_front();
                check($sformatf("out%0d_beat", idx), {c, d}, e);
            end
        end else if (!v) begin
            check($sformatf("out%0d_bubble_ctrl", idx), 40'(c), 40'h0);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && !flush) begin
            mon_one(0, out_valid0, out_ctrl0, out_data0);
            mon_one(1, out_valid1, out_ctrl1, out_data1);
        end
    end

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0;
        out_ready = 1'b0;
        #1 reset = 1'b1;
        #2;
        check_idle("por");
        check("por_ready0", 40'(in_ready0), 40'h1);
        check("por_data0", 40'(out_data0), 40'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // Streaming: one beat per cycle, occupancy pinned at 1.
        out_ready = 1'b1;
        send(8'h81, 32'h10);
        for (int i = 1; i < 4; i++) begin
            check("stream_occ", 40'(occ0), 40'h1);
            check("stream_data", 40'(out_data0), 40'(32'h10 + 32'(i) - 32'h1));
            send(8'h81, 32'h10 + 32'(i));
        end
        check("stream_last", 40'(out_data0), 40'h13);
        idle(1);
        check_idle("stream_empty");

        // Backpressure: A0 in main, A1 in skid, A2 held upstream.
        out_ready = 1'b0;
        send(8'h82, 32'hA0);
        check("bp_occ1", 40'(occ0), 40'h1);
        send(8'h82, 32'hA1);
        check("bp_occ2", 40'(occ0), 40'h2);
        check("bp_ready", 40'(in_ready0), 40'h0);
        in_ctrl = 8'h82;
        in_data = 32'hA2;
        exp_q0.push_back({8'h82, 32'hA2});
        exp_q1.push_back({8'h82, 32'hA2});
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("bp_hold_occ", 40'(occ0), 40'h2);
        check("bp_hold_data", 40'(out_data0), 40'hA0);
        check("bp_hold_ready", 40'(in_ready0), 40'h0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_rel_data", 40'(out_data0), 40'hA1);
        check("bp_rel_occ", 40'(occ0), 40'h1);
        check("bp_rel_ready", 40'(in_ready0), 40'h1);
        @(posedge clk);
        #1;
        check("bp_a2_data", 40'(out_data0), 40'hA2);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("bp_drained", 40'(exp_q0.size()), 40'h0);
        check_idle("bp_empty");

        // Flush at FULL with a beat on the input that must be dropped.
        out_ready = 1'b0;
        send(8'h01, 32'hB0);
        send(8'h02, 32'hB1);
        in_valid = 1'b0;
        check("fl_occ_full", 40'(occ1), 40'h2);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_ctrl  = 8'h3F;
        in_data  = 32'hFF;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        clear_sb();
        check_idle("fl_after");
        check("fl_ready0", 40'(in_ready0), 40'h1);
        check("fl_hold_data0", 40'(out_data0), 40'hB0);
        check("fl_clear_data1", 40'(out_data1), 40'h0);
        out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("fl_stays_empty", 40'(occ0), 40'h0);

        // Bubble: two idle input cycles give exactly two invalid/zero-ctrl output cycles.
        send(8'h81, 32'h50);
        send(8'h81, 32'h51);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_idle("bub1");
        check("drain_hold_data0", 40'(out_data0), 40'h51);
        check("drain_clear_data1", 40'(out_data1), 40'h0);
        @(posedge clk);
        #1;
        check_idle("bub2");
        send(8'h81, 32'h52);
        check("bub_end_valid", 40'(out_valid0), 40'h1);
        check("bub_end_ctrl", 40'(out_ctrl0), 40'h81);
        send(8'h81, 32'h53);
        idle(2);
        check("bub_drained", 40'(exp_q1.size()), 40'h0);

        // Reset in the middle of a stalled burst.
        out_ready = 1'b0;
        send(8'h11, 32'hC0);
        send(8'h11, 32'hC1);
        in_data = 32'hC2;
        #3 reset = 1'b1;
        #1;
        check_idle("rst_mid");
        check("rst_mid_data0", 40'(out_data0), 40'h0);
        clear_sb();
        in_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_rel_ready0", 40'(in_ready0), 40'h1);
        check("rst_rel_ready1", 40'(in_ready1), 40'h1);
        check("rst_rel_occ", 40'(occ0), 40'h0);

        // Random valid/ready traffic; scoreboard checks order and completeness.
        rnd_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 4000; n++) begin
                    idle($urandom_range(0, 2));
                    send(8'($urandom_range(1, 255)), $urandom);
                end
                in_valid = 1'b0;
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (exp_q0.size() == 0 && exp_q1.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check("rnd_drained0", 40'(exp_q0.size()), 40'h0);
        check("rnd_drained1", 40'(exp_q1.size()), 40'h0);
        check_idle("rnd_empty");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
